// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that pairs two bytes into a 16-bit command word with a
// sticky ready flag and an inter-byte timeout to recover pairing alignment.
module uart_cmd_rx #(
    parameter int unsigned BAUD_CNT = 2604,
    parameter int unsigned TMO_CNT  = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam int unsigned BW = $clog2(BAUD_CNT) + 1;
    localparam int unsigned TW = $clog2(TMO_CNT) + 1;
    localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_CNT);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CNT / 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_done_q, byte_done_d;
    logic          frm_err_q, frm_err_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic          expire;

    logic [15:0]   cmd_q, cmd_d;
    logic          rdy_q, rdy_d;
    logic          hi_pend_q, hi_pend_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Synchroniser and edge-history flops preset high so reset is not a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign expire = (baud_q == BW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            frm_err_q   <= frm_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frm_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    baud_d  = BAUD_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (!expire) begin
                    baud_d = baud_q - BW'(1);
                end else if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    baud_d  = BAUD_FULL;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!expire) begin
                    baud_d = baud_q - BW'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    baud_d  = BAUD_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    baud_d = baud_q - BW'(1);
                end else begin
                    state_d     = IDLE;
                    byte_done_d = rx_s_q;
                    frm_err_d   = !rx_s_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            rdy_q     <= 1'b0;
            hi_pend_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            cmd_q     <= cmd_d;
            rdy_q     <= rdy_d;
            hi_pend_q <= hi_pend_d;
            tmo_q     <= tmo_d;
        end
    end

    // A completed low byte outranks the consumer's clear so a fresh word is never dropped.
    always_comb begin
        cmd_d     = cmd_q;
        rdy_d     = rdy_q;
        hi_pend_d = hi_pend_q;
        tmo_d     = tmo_q;
        if (byte_done_q && !hi_pend_q) begin
            cmd_d[15:8] = shift_q;
            hi_pend_d   = 1'b1;
            tmo_d       = '0;
            rdy_d       = 1'b0;
        end else if (byte_done_q) begin
            cmd_d[7:0] = shift_q;
            hi_pend_d  = 1'b0;
            tmo_d      = '0;
            rdy_d      = 1'b1;
        end else begin
            if (clr_cmd_rdy) begin
                rdy_d = 1'b0;
            end
            if (hi_pend_q) begin
                if (tmo_q == TMO_LAST) begin
                    hi_pend_d = 1'b0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: table of byte/clear/idle steps plus
// hand-written glitch, mid-byte reset and clear/set collision sequences.
module tb_uart_cmd_rx;

    localparam int unsigned BAUD = 16;
    localparam int unsigned TMO  = 1000;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int n_vec = 0;
    int n_bad = 0;
    int frm_pulses = 0;

    uart_cmd_rx #(.BAUD_CNT(BAUD), .TMO_CNT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .frm_err    (frm_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge clk) begin
        if (frm_err === 1'b1) frm_pulses <= frm_pulses + 1;
    end

    typedef enum {K_BYTE, K_CLR, K_IDLE} kind_t;
    typedef struct {
        kind_t       kind;
        logic [7:0]  b;
        bit          stop;
        int          gap;
        logic [15:0] exp_cmd;
        bit          exp_rdy;
        int          exp_frm;
        bit          chk_rise;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One frame = 10 bit periods driven on falling edges; iteration c is the
    // falling edge after rising edge c, so the stop sample lands at edge 155
    // and the pairing logic updates at edge 156.
    task automatic send_byte(input logic [7:0] b, input bit stop, input int clr_at,
                             input int rst_at, input bit chk_rise);
        int bi;
        for (int c = 0; c < 10 * BAUD; c++) begin
            @(negedge clk);
            if (chk_rise && c == 155) chk("rdy_before_rise", cmd_rdy, 0);
            if (chk_rise && c == 156) chk("rdy_rise", cmd_rdy, 1);
            if (c == rst_at) begin
                rst_n       = 1'b0;
                RX          = 1'b1;
                clr_cmd_rdy = 1'b0;
                #1;
                chk("rst_mid_cmd", cmd, 0);
                chk("rst_mid_rdy", cmd_rdy, 0);
                chk("rst_mid_frm", frm_err, 0);
                return;
            end
            bi = c / BAUD;
            if (bi == 0)      RX = 1'b0;
            else if (bi == 9) RX = stop;
            else              RX = b[bi-1];
            clr_cmd_rdy = (c == clr_at);
        end
        @(negedge clk);
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
    endtask

    int frm0;

    initial begin
        vt[0]  = '{K_BYTE, 8'hA5, 1'b1, 4,    16'hA500, 1'b0, 0, 1'b0};
        vt[1]  = '{K_BYTE, 8'h3C, 1'b1, 4,    16'hA53C, 1'b1, 0, 1'b1};
        vt[2]  = '{K_CLR,  8'h00, 1'b1, 0,    16'hA53C, 1'b0, 0, 1'b0};
        vt[3]  = '{K_BYTE, 8'h12, 1'b1, 4,    16'h123C, 1'b0, 0, 1'b0};
        vt[4]  = '{K_IDLE, 8'h00, 1'b1, 1200, 16'h123C, 1'b0, 0, 1'b0};
        vt[5]  = '{K_BYTE, 8'h55, 1'b0, 4,    16'h123C, 1'b0, 1, 1'b0};
        vt[6]  = '{K_BYTE, 8'h01, 1'b1, 4,    16'h013C, 1'b0, 0, 1'b0};
        vt[7]  = '{K_BYTE, 8'h02, 1'b1, 4,    16'h0102, 1'b1, 0, 1'b0};
        vt[8]  = '{K_BYTE, 8'hFF, 1'b1, 4,    16'hFF02, 1'b0, 0, 1'b0};
        vt[9]  = '{K_IDLE, 8'h00, 1'b1, 1100, 16'hFF02, 1'b0, 0, 1'b0};
        vt[10] = '{K_BYTE, 8'hC3, 1'b1, 4,    16'hC302, 1'b0, 0, 1'b0};
        vt[11] = '{K_BYTE, 8'h0F, 1'b1, 4,    16'hC30F, 1'b1, 0, 1'b0};

        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        #1;
        chk("reset_cmd", cmd, 0);
        chk("reset_rdy", cmd_rdy, 0);
        chk("reset_frm", frm_err, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            frm0 = frm_pulses;
            case (vt[i].kind)
                K_BYTE: send_byte(vt[i].b, vt[i].stop, -1, -1, vt[i].chk_rise);
                K_CLR: begin
                    @(negedge clk);
                    clr_cmd_rdy = 1'b1;
                    @(negedge clk);
                    clr_cmd_rdy = 1'b0;
                end
                default: ;
            endcase
            repeat (vt[i].gap) @(negedge clk);
            chk($sformatf("vec%0d_cmd", i), cmd, vt[i].exp_cmd);
            chk($sformatf("vec%0d_rdy", i), cmd_rdy, vt[i].exp_rdy);
            chk($sformatf("vec%0d_frm", i), frm_pulses - frm0, vt[i].exp_frm);
        end

        // Short low glitch while idle: start bit rejected at the half-bit check.
        frm0 = frm_pulses;
        @(negedge clk);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_cmd", cmd, 16'hC30F);
        chk("glitch_rdy", cmd_rdy, 1);
        chk("glitch_frm", frm_pulses - frm0, 0);

        // Reset in the middle of the data bits, then a clean pair.
        send_byte(8'h77, 1'b1, -1, 60, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_hold_cmd", cmd, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h9A, 1'b1, -1, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("post_rst_hi", cmd, 16'h9A00);
        send_byte(8'hBC, 1'b1, -1, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("post_rst_cmd", cmd, 16'h9ABC);
        chk("post_rst_rdy", cmd_rdy, 1);

        // Clear strobe lands in the same cycle the low byte completes.
        send_byte(8'h11, 1'b1, -1, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("coll_hi_rdy", cmd_rdy, 0);
        send_byte(8'h22, 1'b1, 155, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("coll_cmd", cmd, 16'h1122);
        chk("coll_rdy", cmd_rdy, 1);

        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("final_clr_rdy", cmd_rdy, 0);
        chk("final_clr_cmd", cmd, 16'h1122);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Serial front end for the command processor. Receives 8N1 UART bytes from the BLE module on RX and assembles two bytes into a 16-bit command word. Presents the word with a sticky cmd_rdy flag, cleared by the consumer's clr_cmd_rdy strobe. Integrates bit-level reception, framing check, byte pairing and an inter-byte timeout so that a lost byte cannot permanently misalign command words.

Parameters:
BAUD_CNT, 2604, clocks per bit period (50 MHz / 19200 baud); minimum legal value 8.
TMO_CNT, 2000000, clocks allowed between completion of the high byte and completion of the low byte before the pair is abandoned (40 ms).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
RX  input  1  asynchronous serial line, idle high
clr_cmd_rdy  input  1  single-cycle strobe from the consumer; clears cmd_rdy
cmd  output  16  last complete command word: {first byte, second byte}
cmd_rdy  output  1  sticky; high while cmd holds an unconsumed word
frm_err  output  1  one-cycle pulse when a byte is rejected for a bad stop bit

Behaviour:
- Reset: cmd=16'h0000, cmd_rdy=0, frm_err=0. Bit state machine in IDLE, byte pairing expects the high byte, all counters 0. RX synchroniser flops preset to 1 so reset does not create a false start.
- RX passes through two flops; all decisions use the second flop output (rx_s). Two-cycle synchroniser latency is accepted.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rx_s (previous sample 1, current 0) loads the baud counter with BAUD_CNT/2 (integer divide), then enters START.
  - START: when the baud counter expires, rx_s is checked. If 1, it was a glitch: go to IDLE, no error. If 0, reload BAUD_CNT and enter DATA with bit index 0.
  - DATA: on each expiry, shift rx_s into bit 7 of the shift register (LSB received first) and reload BAUD_CNT. After the 8th bit, enter STOP.
  - STOP: on expiry, if rx_s=1 the byte is valid; generate byte_done for one cycle. If rx_s=0, pulse frm_err for one cycle and discard the byte. Either way return to IDLE on that same cycle, so a start edge on the very next sample is accepted.
- Byte pairing, using a flag hi_pending:
  - byte_done with hi_pending=0: latch the byte into cmd[15:8], set hi_pending=1, clear the timeout counter, and clear cmd_rdy in that cycle, because the word is now being overwritten.
  - byte_done with hi_pending=1: latch the byte into cmd[7:0], clear hi_pending, and set cmd_rdy on the following clock edge. cmd[15:0] is then complete and stable.
  - While hi_pending=1 the timeout counter increments every clock. When it reaches TMO_CNT-1, hi_pending clears; the next byte is treated as a high byte. cmd[15:8] keeps its partial value, and cmd_rdy stays 0.
  - A framing error does not change hi_pending; the timeout alone resynchronises pairing.
- cmd_rdy priority, per clock:
  - Setting (low byte done) beats clr_cmd_rdy in the same cycle, so the new word is never lost.
  - clr_cmd_rdy beats hold.
  - High-byte completion clears cmd_rdy.
  - clr_cmd_rdy while cmd_rdy=0 has no effect.
- cmd changes only on byte_done; it is never cleared by clr_cmd_rdy.
- Reset asserted mid-byte aborts reception immediately. The partial byte and pairing state are lost, and outputs return to their reset values.
- Counters: baud counter uses clog2(BAUD_CNT)+1 bits; timeout counter uses clog2(TMO_CNT)+1 bits. Neither counter wraps in operation; both are reloaded or cleared before overflow.

Test Plan:
- Send 8'hA5 then 8'h3C with BAUD_CNT=16, TMO_CNT=1000 -> cmd_rdy rises one clock after the second stop-bit sample; cmd=16'hA53C; frm_err never pulses.
- With cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle and cmd still 16'hA53C. Then send 8'h12 -> cmd_rdy stays 0 and cmd[15:8]=8'h12 after its stop bit.
- Send 8'h55 with the stop bit forced low -> exactly one frm_err pulse, cmd unchanged. Then send 8'h01, 8'h02 -> the pair still completes, with cmd=16'h0102 (hi_pending was unaffected).
- Send 8'hFF, wait 1100 clocks, then send 8'hC3, 8'h0F -> the timeout discards 8'hFF; cmd=16'hC30F and cmd_rdy=1 only after 8'h0F.
- Drive a 3-clock low glitch on RX while idle -> no byte accepted, no frm_err. Separately, assert rst_n low midway through the data bits -> cmd=0 and cmd_rdy=0; a following full pair 8'h9A, 8'hBC is received correctly.
- Time the low byte's completion to coincide with clr_cmd_rdy=1 -> cmd_rdy ends at 1 and the new word is present.
